fht_transpose_buf: RTL and testbench

FHT_TRANSPOSE_BUF -- requirements
Module: fht_transpose_buf

---
 rtl/fht_transpose_buf.sv | 94 +++++++++
 tb/tb_fht_transpose_buf.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_transpose_buf.sv
// 8x8 ping-pong transpose buffer between the row and column FHT stages.
// Optional input-overrun check is built when FHT_TBUF_OVR_CHK_EN is defined.
module fht_transpose_buf #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic         out_last,
  output logic         err
);

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DRAINING = 2'd3;

  logic [1:0]          bank_st [2];
  logic                wr_sel;
  logic                rd_sel;
  logic [5:0]          wr_cnt;
  logic [5:0]          rd_cnt;
  logic [5:0]          rd_addr;
  logic                wr_fire;
  logic                rd_fire;
  logic signed [N-1:0] mem [2][64];

  assign in_ready  = (bank_st[wr_sel] == EMPTY) || (bank_st[wr_sel] == FILLING);
  assign out_valid = (bank_st[rd_sel] == FULL)  || (bank_st[rd_sel] == DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Column-major read of a row-major frame: swap the row/col fields.
  assign rd_addr   = {rd_cnt[2:0], rd_cnt[5:3]};
  assign out_data  = mem[rd_sel][rd_addr];
  assign out_last  = out_valid && (rd_cnt == 6'd63);

  // Write and read banks are always distinct when both fire, so the two
  // bank-state updates below never target the same entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      wr_cnt     <= 6'd0;
      rd_cnt     <= 6'd0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == 6'd63) begin
          bank_st[wr_sel] <= FULL;
          wr_sel          <= ~wr_sel;
        end else begin
          bank_st[wr_sel] <= FILLING;
        end
        wr_cnt <= wr_cnt + 6'd1;
      end
      if (rd_fire) begin
        if (rd_cnt == 6'd63) begin
          bank_st[rd_sel] <= EMPTY;
          rd_sel          <= ~rd_sel;
        end else begin
          bank_st[rd_sel] <= DRAINING;
        end
        rd_cnt <= rd_cnt + 6'd1;
      end
    end
  end

  // Sample storage carries no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_sel][wr_cnt] <= in_data;
    end
  end

`ifdef FHT_TBUF_OVR_CHK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fht_transpose_buf.sv
// Scoreboard bench for fht_transpose_buf: a reference transpose of every
// accepted frame is queued and compared against each accepted output.
module tb_fht_transpose_buf;
  localparam int N = 9;

`ifdef FHT_TBUF_OVR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         out_last;
  logic         err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N:0]   sb [$];
  logic [N-1:0] fbuf [64];
  int           wcnt = 0;

  fht_transpose_buf #(.N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model and output scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [N:0] exp_v;
    if (!rstn) begin
      sb.delete();
      wcnt = 0;
    end else begin
      if (in_valid && in_ready) begin
        fbuf[wcnt] = in_data;
        wcnt++;
        if (wcnt == 64) begin
          for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
              sb.push_back({(c == 7 && r == 7), fbuf[r*8 + c]});
          wcnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got last=%0b data=%0d, required no output", out_last, out_data);
        end else begin
          exp_v = sb.pop_front();
          if ({out_last, out_data} !== exp_v) begin
            n_fail++;
            $display("FAIL sb_data: got last=%0b data=%0d, required last=%0b data=%0d",
                     out_last, out_data, exp_v[N], exp_v[N-1:0]);
          end
        end
      end
    end
  end

  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) clk_step();
    rstn = 1'b1;
    n_cmp++;
    if ({in_ready, out_valid, out_last, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_state: got rdy/vld/last/err=%b, required 1000",
               {in_ready, out_valid, out_last, err});
    end
  endtask

  task automatic test_single_frame;
    int early = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) early++;
      in_valid = 1'b1;
      in_data  = N'(i);
      clk_step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL single_fill: got %0d bad cycles, required 0", early);
    end
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_latency: got vld/rdy=%b, required 11", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    repeat (64) clk_step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain: got vld=%0b pending=%0d, required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_pingpong_full;
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data  = N'(i * 3 + 5);
      clk_step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL pp_full: got rdy/vld=%b, required 01", {in_ready, out_valid});
    end
    out_ready = 1'b1;
    repeat (63) clk_step();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_early_ready: got %0b, required 0", in_ready);
    end
    clk_step();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL pp_free: got rdy/vld=%b, required 11", {in_ready, out_valid});
    end
    repeat (64) clk_step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL pp_drain: got vld=%0b pending=%0d, required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int drops = 0;
    int gaps  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 320; c++) begin
      if (c >= 64 && out_valid !== 1'b1) gaps++;
      if (c < 256) begin
        if (in_ready !== 1'b1) drops++;
        in_valid = 1'b1;
        in_data  = N'($urandom_range((1 << N) - 1, 0));
      end else begin
        in_valid = 1'b0;
      end
      clk_step();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL stream_ready: got %0d ready drops, required 0", drops);
    end
    n_cmp++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL stream_valid: got %0d valid gaps, required 0", gaps);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: got vld=%0b pending=%0d, required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_backpressure;
    int           writes = 0;
    int           bad    = 0;
    int           cyc    = 0;
    logic         stall  = 1'b0;
    logic [N-1:0] held   = '0;
    while ((writes < 128 || out_valid) && cyc < 4000) begin
      if (stall && (out_valid !== 1'b1 || out_data !== held)) bad++;
      in_valid  = (writes < 128) && in_ready && ($urandom_range(3, 0) != 0);
      in_data   = N'($urandom_range((1 << N) - 1, 0));
      out_ready = ($urandom_range(1, 0) == 1);
      stall     = out_valid && !out_ready;
      held      = out_data;
      if (in_valid) writes++;
      clk_step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d cycles, required < 4000", cyc);
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable stalls, required 0", bad);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_pending: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = N'(100 + i);
      clk_step();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    clk_step();
    rstn = 1'b1;
    n_cmp++;
    if ({in_ready, out_valid, out_last} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_reset: got rdy/vld/last=%b, required 100", {in_ready, out_valid, out_last});
    end
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = N'(-256 + i * 8);
      clk_step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame: got vld=%0b, required 1", out_valid);
    end
    out_ready = 1'b1;
    repeat (64) clk_step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL mid_drain: got vld=%0b pending=%0d, required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data  = N'(i);
      clk_step();
    end
    n_cmp++;
    if (err !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pre: got err/rdy=%b, required 00", {err, in_ready});
    end
    in_valid = 1'b1;
    clk_step();
    in_valid = 1'b0;
    n_cmp++;
    if (err !== ERR_EXP) begin
      n_fail++;
      $display("FAIL ovr_set: got err=%0b, required %0b", err, ERR_EXP);
    end
    repeat (3) clk_step();
    n_cmp++;
    if (err !== ERR_EXP) begin
      n_fail++;
      $display("FAIL ovr_hold: got err=%0b, required %0b", err, ERR_EXP);
    end
    rstn = 1'b0;
    clk_step();
    rstn = 1'b1;
    n_cmp++;
    if ({err, in_ready, out_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL ovr_clear: got err/rdy/vld=%b, required 010", {err, in_ready, out_valid});
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_pingpong_full();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
